mealy_1100_detector: RTL and testbench



---
 rtl/mealy_1100_pkg.sv | 13 +
 rtl/mealy_1100_detector.sv | 41 ++++
 tb/tb_mealy_1100_detector.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mealy_1100_pkg.sv
// Shared types and constants for the serial 1100 pattern detector.
package mealy_1100_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  localparam logic [3:0] DETECT_SEQ = 4'b1100;

endpackage

// File: rtl/mealy_1100_detector.sv
// Overlap-aware Mealy detector for the serial sequence 1100; z1 is combinational.
module mealy_1100_detector
  import mealy_1100_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic z1
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // A run of three or more 1s keeps the "11" prefix alive in S2.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S2 : S0;
      S2:      state_d = in ? S2 : S3;
      S3:      state_d = in ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    z1 = 1'b0;
    if (!reset && (state_q == S3) && !in) begin
      z1 = 1'b1;
    end
  end

endmodule

// File: tb/tb_mealy_1100_detector.sv
// Directed table-driven bench for mealy_1100_detector plus mid-cycle glitch sequences.
module tb_mealy_1100_detector;
  import mealy_1100_pkg::*;

  logic clk;
  logic reset;
  logic in_b;
  logic z1;

  int tests;
  int fails;

  typedef struct {
    string  tag;
    logic   rst;
    logic   din;
    logic   exp_z1;
    state_e exp_st;
  } vec_t;

  vec_t vecs[$];

  mealy_1100_detector dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_b),
    .z1    (z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input string tag, input logic rst, input logic din,
                              input logic ez, input state_e est);
    vec_t v;
    v.tag = tag;
    v.rst = rst;
    v.din = din;
    v.exp_z1 = ez;
    v.exp_st = est;
    vecs.push_back(v);
  endfunction

  // Drive inputs mid-low-phase, check z1 before the edge and state after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst;
    in_b  = v.din;
    #1;
    check($sformatf("%s[%0d].z1", v.tag, idx), {1'b0, z1}, {1'b0, v.exp_z1});
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].state", v.tag, idx), dut.state_q, v.exp_st);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    in_b  = 1'b0;

    // Reset hold with toggling input
    add("rst_hold", 1, 0, 0, S0);
    add("rst_hold", 1, 1, 0, S0);
    // Basic 1100
    add("basic", 0, 1, 0, S1);
    add("basic", 0, 1, 0, S2);
    add("basic", 0, 0, 0, S3);
    add("basic", 0, 0, 1, S0);
    // Long ones prefix 111100
    add("long1", 0, 1, 0, S1);
    add("long1", 0, 1, 0, S2);
    add("long1", 0, 1, 0, S2);
    add("long1", 0, 1, 0, S2);
    add("long1", 0, 0, 0, S3);
    add("long1", 0, 0, 1, S0);
    // Near miss 1101100
    add("near", 0, 1, 0, S1);
    add("near", 0, 1, 0, S2);
    add("near", 0, 0, 0, S3);
    add("near", 0, 1, 0, S1);
    add("near", 0, 1, 0, S2);
    add("near", 0, 0, 0, S3);
    add("near", 0, 0, 1, S0);
    // 100: no detect
    add("no100", 0, 1, 0, S1);
    add("no100", 0, 0, 0, S0);
    add("no100", 0, 0, 0, S0);
    // 01101: no detect
    add("no01101", 0, 0, 0, S0);
    add("no01101", 0, 1, 0, S1);
    add("no01101", 0, 1, 0, S2);
    add("no01101", 0, 0, 0, S3);
    add("no01101", 0, 1, 0, S1);
    add("no01101", 0, 0, 0, S0);
    // Reset mid-sequence while in S3 with in=0: z1 forced low
    add("midrst", 0, 1, 0, S1);
    add("midrst", 0, 1, 0, S2);
    add("midrst", 0, 0, 0, S3);
    add("midrst", 1, 0, 0, S0);
    add("midrst", 0, 1, 0, S1);
    add("midrst", 0, 1, 0, S2);
    add("midrst", 0, 0, 0, S3);
    add("midrst", 0, 0, 1, S0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Glitch in S3: in 0->1->0 between edges, edge sees 0
    vecs.delete();
    add("pre_g1", 0, 1, 0, S1);
    add("pre_g1", 0, 1, 0, S2);
    add("pre_g1", 0, 0, 0, S3);
    foreach (vecs[i]) apply(vecs[i], i);
    @(negedge clk);
    in_b = 1'b0; #1; check("glitch1.a", {1'b0, z1}, 2'd1);
    in_b = 1'b1; #1; check("glitch1.b", {1'b0, z1}, 2'd0);
    in_b = 1'b0; #1; check("glitch1.c", {1'b0, z1}, 2'd1);
    @(posedge clk); #1;
    check("glitch1.state", dut.state_q, S0);

    // Glitch in S3: in 1->0->1 between edges, edge sees 1
    vecs.delete();
    add("pre_g2", 0, 1, 0, S1);
    add("pre_g2", 0, 1, 0, S2);
    add("pre_g2", 0, 0, 0, S3);
    foreach (vecs[i]) apply(vecs[i], i);
    @(negedge clk);
    in_b = 1'b1; #1; check("glitch2.a", {1'b0, z1}, 2'd0);
    in_b = 1'b0; #1; check("glitch2.b", {1'b0, z1}, 2'd1);
    in_b = 1'b1; #1; check("glitch2.c", {1'b0, z1}, 2'd0);
    @(posedge clk); #1;
    check("glitch2.state", dut.state_q, S1);

    // Reset asserted combinationally masks z1 in S3
    vecs.delete();
    add("pre_rm", 0, 1, 0, S2);
    add("pre_rm", 0, 0, 0, S3);
    foreach (vecs[i]) apply(vecs[i], i);
    @(negedge clk);
    in_b = 1'b0;
    reset = 1'b1; #1; check("rstmask.on", {1'b0, z1}, 2'd0);
    reset = 1'b0; #1; check("rstmask.off", {1'b0, z1}, 2'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmask.state", dut.state_q, S0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
